dff_bank_sequencer: RTL and testbench

Controller for a bank of WIDTH D flip-flops. Each flip-flop has synchronous active-low set and clear, plus D/Q/Q_n. The block sequences the bank through clear, preset, parallel load, shift and rotate operations, paced by a programmable prescaler so lab boards can show steps on LEDs. It drives every set_n/rst_n/D line of the bank and reads back the bank's Q outputs.

---
 rtl/dff_bank_sequencer.sv | 178 +++++++++++++++++
 tb/tb_dff_bank_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_sequencer.sv
// Sequencer for a bank of WIDTH D flip-flops with synchronous active-low set/clear.
// Walks the bank through clear, preset, load, shift and rotate steps paced by a prescaler.
module dff_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] pattern,
    input  logic [7:0]       steps,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] ff_q,
    output logic [WIDTH-1:0] ff_set_n,
    output logic [WIDTH-1:0] ff_rst_n,
    output logic [WIDTH-1:0] ff_d,
    output logic             busy,
    output logic             done,
    output logic [7:0]       step_cnt
);

    localparam int                DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_ZERO = DIV_W'(0);

    localparam logic [2:0] MODE_HOLD   = 3'd0;
    localparam logic [2:0] MODE_CLEAR  = 3'd1;
    localparam logic [2:0] MODE_PRESET = 3'd2;
    localparam logic [2:0] MODE_LOAD   = 3'd3;
    localparam logic [2:0] MODE_SHL    = 3'd4;
    localparam logic [2:0] MODE_SHR    = 3'd5;
    localparam logic [2:0] MODE_ROTL   = 3'd6;
    localparam logic [2:0] MODE_ROTR   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [2:0]         mode_q,     mode_d;
    logic [WIDTH-1:0]   pattern_q,  pattern_d;
    logic [7:0]         steps_q,    steps_d;
    logic [DIV_W-1:0]   div_cnt_q,  div_cnt_d;
    logic [7:0]         step_cnt_q, step_cnt_d;

    logic               tick_s;
    logic               last_step_s;
    logic [WIDTH-1:0]   ff_set_n_s;
    logic [WIDTH-1:0]   ff_rst_n_s;
    logic [WIDTH-1:0]   ff_d_s;

    assign tick_s      = (state_q == ST_RUN) && (div_cnt_q == DIV_LAST);
    assign last_step_s = (step_cnt_q == (steps_q - 8'd1));

    // Next-state, operand latching, prescaler and step counting
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pattern_d  = pattern_q;
        steps_d    = steps_q;
        div_cnt_d  = div_cnt_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    pattern_d  = pattern;
                    steps_d    = steps;
                    step_cnt_d = 8'd0;
                    state_d    = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                div_cnt_d = DIV_ZERO;
                if (abort) begin
                    state_d = ST_DONE;
                end else if ((mode_q >= MODE_SHL) && (steps_q != 8'd0)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_RUN: begin
                if (tick_s) begin
                    div_cnt_d  = DIV_ZERO;
                    step_cnt_d = step_cnt_q + 8'd1;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
                // An abort still lets this cycle's step land; it only stops further ones.
                if (abort || (tick_s && last_step_s)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bank drive decode; every path defaults to holding the bank's current value
    always_comb begin
        ff_set_n_s = {WIDTH{1'b1}};
        ff_rst_n_s = {WIDTH{1'b1}};
        ff_d_s     = ff_q;
        case (state_q)
            ST_INIT: begin
                case (mode_q)
                    MODE_HOLD:   ff_d_s     = ff_q;
                    MODE_CLEAR:  ff_rst_n_s = {WIDTH{1'b0}};
                    MODE_PRESET: ff_set_n_s = {WIDTH{1'b0}};
                    MODE_LOAD,
                    MODE_SHL,
                    MODE_SHR,
                    MODE_ROTL,
                    MODE_ROTR:   ff_d_s     = pattern_q;
                    default:     ff_d_s     = ff_q;
                endcase
            end
            ST_RUN: begin
                if (tick_s) begin
                    case (mode_q)
                        MODE_SHL:  ff_d_s = {ff_q[WIDTH-2:0], ser_in};
                        MODE_SHR:  ff_d_s = {ser_in, ff_q[WIDTH-1:1]};
                        MODE_ROTL: ff_d_s = {ff_q[WIDTH-2:0], ff_q[WIDTH-1]};
                        MODE_ROTR: ff_d_s = {ff_q[0], ff_q[WIDTH-1:1]};
                        default:   ff_d_s = ff_q;
                    endcase
                end else begin
                    ff_d_s = ff_q;
                end
            end
            default: begin
                ff_d_s = ff_q;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 3'd0;
            pattern_q  <= {WIDTH{1'b0}};
            steps_q    <= 8'd0;
            div_cnt_q  <= DIV_ZERO;
            step_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            steps_q    <= steps_d;
            div_cnt_q  <= div_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign ff_set_n = ff_set_n_s;
    assign ff_rst_n = ff_rst_n_s;
    assign ff_d     = ff_d_s;
    assign busy     = (state_q == ST_INIT) || (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_dff_bank_sequencer.sv
// Self-checking bench: a behavioural flip-flop bank closes the loop, and a
// trajectory model predicts the bank contents at every cycle of an operation.
module tb_dff_bank_sequencer;

    localparam int WIDTH = 4;
    localparam int DIV   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] mode;
    logic [3:0] pattern;
    logic [7:0] steps;
    logic       ser_in;
    logic [3:0] ff_q;
    logic [3:0] ff_set_n;
    logic [3:0] ff_rst_n;
    logic [3:0] ff_d;
    logic       busy;
    logic       done;
    logic [7:0] step_cnt;

    int checks   = 0;
    int failures = 0;

    logic [3:0] bank_q;
    logic       load_req;
    logic [3:0] load_val;
    logic       both_low_seen = 1'b0;

    logic [3:0] hist[$];
    logic [3:0] exp_q[$];
    int         busy_cnt;
    logic       timed_out;
    logic [7:0] sc_done;
    logic       busy_after;
    logic       done_after;
    logic [3:0] init_set;
    logic [3:0] init_rst;
    logic [3:0] init_d;

    dff_bank_sequencer #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .pattern(pattern), .steps(steps), .ser_in(ser_in), .ff_q(ff_q),
        .ff_set_n(ff_set_n), .ff_rst_n(ff_rst_n), .ff_d(ff_d),
        .busy(busy), .done(done), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural bank: clear beats set beats D; the bench can preload it directly
    always @(posedge clk) begin
        if (load_req) bank_q <= load_val;
        else          bank_q <= (ff_d | ~ff_set_n) & ff_rst_n;
    end
    assign ff_q = bank_q;

    always @(negedge clk) begin
        if ((~ff_set_n & ~ff_rst_n) != 4'b0000) both_low_seen <= 1'b1;
    end

    function automatic logic [3:0] step_fn(input logic [2:0] m, input logic [3:0] q, input logic ser);
        int v;
        int r;
        v = int'(q);
        case (m)
            3'd4:    r = (v * 2 + int'(ser)) % 16;
            3'd5:    r = v / 2 + int'(ser) * 8;
            3'd6:    r = (v * 2) % 16 + v / 8;
            3'd7:    r = v / 2 + (v % 2) * 8;
            default: r = v;
        endcase
        return r[3:0];
    endfunction

    function automatic logic [3:0] init_fn(input logic [2:0] m, input logic [3:0] p, input logic [3:0] q);
        case (m)
            3'd0:    return q;
            3'd1:    return 4'b0000;
            3'd2:    return 4'b1111;
            default: return p;
        endcase
    endfunction

    // Expected bank value seen at each negedge from INIT through DONE
    task automatic build_expected(input logic [2:0] m, input logic [3:0] p, input logic [7:0] s,
                                  input logic ser, input logic [3:0] q0);
        logic [3:0] q;
        exp_q.delete();
        exp_q.push_back(q0);
        q = init_fn(m, p, q0);
        if (m >= 3'd4 && s != 8'd0) begin
            for (int j = 1; j <= int'(s) * DIV; j++) begin
                exp_q.push_back(q);
                if (j % DIV == 0) q = step_fn(m, q, ser);
            end
        end
        exp_q.push_back(q);
    endtask

    task automatic preload(input logic [3:0] v);
        @(negedge clk);
        load_req = 1'b1;
        load_val = v;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Issue one operation and record what the bank and status look like each cycle
    task automatic run_op(input logic [2:0] m, input logic [3:0] p, input logic [7:0] s,
                          input logic ser, input logic ab);
        @(negedge clk);
        mode = m; pattern = p; steps = s; ser_in = ser; start = 1'b1; abort = ab;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        mode = 3'($urandom); pattern = 4'($urandom); steps = 8'($urandom);
        hist.delete();
        busy_cnt = 0;
        timed_out = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (n > 0) @(negedge clk);
            hist.push_back(ff_q);
            if (n == 0) begin init_set = ff_set_n; init_rst = ff_rst_n; init_d = ff_d; end
            if (busy) busy_cnt++;
            if (done) begin sc_done = step_cnt; timed_out = 1'b0; break; end
        end
        @(negedge clk);
        busy_after = busy;
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 3'd0; pattern = 4'd0;
        steps = 8'd0; ser_in = 1'b0; load_req = 1'b1; load_val = 4'b0110;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_req = 1'b0;
        @(negedge clk);
        checks++; if (ff_d !== 4'b0110) begin failures++; $display("FAIL reset_ff_d got %b want 0110", ff_d); end
        checks++; if (ff_set_n !== 4'b1111) begin failures++; $display("FAIL reset_set_n got %b want 1111", ff_set_n); end
        checks++; if (ff_rst_n !== 4'b1111) begin failures++; $display("FAIL reset_rst_n got %b want 1111", ff_rst_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (step_cnt !== 8'd0) begin failures++; $display("FAIL reset_step_cnt got %0d want 0", step_cnt); end
        checks++; if (bank_q !== 4'b0110) begin failures++; $display("FAIL reset_bank_hold got %b want 0110", bank_q); end
    endtask

    // Directed table (load, rotl, shr, clear, preset) followed by random operations
    task automatic test_operations();
        logic [2:0] t_m[5] = '{3'd3, 3'd6, 3'd5, 3'd1, 3'd2};
        logic [3:0] t_p[5] = '{4'b1011, 4'b1000, 4'b1111, 4'b1010, 4'b0011};
        logic [7:0] t_s[5] = '{8'd0, 8'd3, 8'd2, 8'd0, 8'd0};
        logic [3:0] t_pre[5] = '{4'b0110, 4'b0000, 4'b0000, 4'b0101, 4'b0000};
        logic       t_doload[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] m; logic [3:0] p; logic [7:0] s; logic ser; logic ab; logic [3:0] q0;
        for (int k = 0; k < 29; k++) begin
            if (k < 5) begin
                m = t_m[k]; p = t_p[k]; s = t_s[k]; ser = 1'b0; ab = 1'b0;
                if (t_doload[k]) preload(t_pre[k]);
            end else begin
                m = 3'($urandom_range(0, 7)); p = 4'($urandom); s = 8'($urandom_range(0, 5));
                ser = 1'($urandom); ab = 1'($urandom);
                if ($urandom_range(0, 1) == 1) preload(4'($urandom));
            end
            q0 = bank_q;
            build_expected(m, p, s, ser, q0);
            run_op(m, p, s, ser, ab);
            checks++;
            if (timed_out) begin
                failures++; $display("FAIL op%0d_timeout got no done want done m=%0d", k, m);
                continue;
            end
            checks++;
            if (busy_cnt != exp_q.size() - 1) begin
                failures++; $display("FAIL op%0d_busy_cycles got %0d want %0d m=%0d s=%0d", k, busy_cnt, exp_q.size() - 1, m, s);
            end
            checks++;
            if (hist.size() != exp_q.size()) begin
                failures++; $display("FAIL op%0d_len got %0d want %0d", k, hist.size(), exp_q.size());
            end else begin
                for (int i = 0; i < hist.size(); i++) begin
                    if (hist[i] !== exp_q[i]) begin
                        failures++; $display("FAIL op%0d_q[%0d] got %b want %b m=%0d", k, i, hist[i], exp_q[i], m);
                    end
                end
            end
            checks++;
            if (sc_done !== ((m >= 3'd4) ? s : 8'd0)) begin
                failures++; $display("FAIL op%0d_step_cnt got %0d want %0d", k, sc_done, (m >= 3'd4) ? s : 8'd0);
            end
            checks++;
            if (init_rst !== ((m == 3'd1) ? 4'b0000 : 4'b1111) || init_set !== ((m == 3'd2) ? 4'b0000 : 4'b1111)) begin
                failures++; $display("FAIL op%0d_init_setrst got set=%b rst=%b m=%0d", k, init_set, init_rst, m);
            end
            checks++;
            if (init_d !== ((m >= 3'd3) ? p : q0)) begin
                failures++; $display("FAIL op%0d_init_d got %b want %b", k, init_d, (m >= 3'd3) ? p : q0);
            end
            checks++;
            if (busy_after !== 1'b0 || done_after !== 1'b0) begin
                failures++; $display("FAIL op%0d_after_done got busy=%b done=%b want 0 0", k, busy_after, done_after);
            end
        end
    endtask

    task automatic test_abort_and_ignored_start();
        logic [3:0] p; logic [3:0] want; logic [3:0] q_done;
        p = 4'($urandom);
        want = step_fn(3'd4, step_fn(3'd4, p, 1'b1), 1'b1);
        @(negedge clk);
        mode = 3'd4; pattern = p; steps = 8'd5; ser_in = 1'b1; start = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            @(negedge clk);
            start = (n == 1) ? 1'b1 : 1'b0;
            if (n == 1) mode = 3'd1;
            abort = (n == 5) ? 1'b1 : 1'b0;
            if (n == 5) start = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL abort_done got %b want 1", done); end
        checks++; if (step_cnt !== 8'd2) begin failures++; $display("FAIL abort_step_cnt got %0d want 2", step_cnt); end
        checks++; if (ff_q !== want) begin failures++; $display("FAIL abort_q got %b want %b", ff_q, want); end
        q_done = ff_q;
        mode = 3'd3; pattern = ~q_done; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || ff_q !== q_done || step_cnt !== 8'd2) begin
                failures++; $display("FAIL ignored_start got busy=%b done=%b q=%b sc=%0d want 0 0 %b 2", busy, done, ff_q, step_cnt, q_done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] q_hold;
        @(negedge clk);
        mode = 3'd7; pattern = 4'b1001; steps = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrun_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrun_status got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (ff_set_n !== 4'b1111 || ff_rst_n !== 4'b1111) begin failures++; $display("FAIL midrun_setrst got %b %b want 1111 1111", ff_set_n, ff_rst_n); end
        checks++; if (ff_d !== ff_q) begin failures++; $display("FAIL midrun_hold got %b want %b", ff_d, ff_q); end
        checks++; if (step_cnt !== 8'd0) begin failures++; $display("FAIL midrun_step_cnt got %0d want 0", step_cnt); end
        q_hold = bank_q;
        @(negedge clk);
        checks++; if (bank_q !== q_hold) begin failures++; $display("FAIL midrun_bank got %b want %b", bank_q, q_hold); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bank_q !== q_hold) begin failures++; $display("FAIL post_reset_idle got busy=%b q=%b want 0 %b", busy, bank_q, q_hold); end
    endtask

    task automatic test_no_conflict();
        checks++;
        if (both_low_seen !== 1'b0) begin failures++; $display("FAIL set_rst_conflict got 1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_operations();
        test_abort_and_ignored_start();
        test_reset_mid_run();
        test_no_conflict();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
